// File: rtl/keypad_pkg.sv
// Shared constants, code type and key-code mapping for the 4x4 keypad scanner.
package keypad_pkg;
  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int CODE_W   = 6;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t KEY_NONE  = 6'd0;
  localparam code_t KEY_RESET = 6'd1;
  localparam code_t KEY_CLOCK = 6'd2;
  localparam code_t KEY_ENTER = 6'd3;
  localparam code_t KEY_SHIFT = 6'd4;
  localparam code_t KEY_AD    = 6'd8;
  localparam code_t KEY_ID    = 6'd12;

  // Column-major numbering: col*4 + row + 1, so 0 stays free for "no key".
  function automatic code_t code_of(input logic [1:0] col, input logic [1:0] row);
    return {2'b00, col, row} + code_t'(1);
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-code bundle; master is the scanner, slave is the keypad/consumer side.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0] row_in;
  logic [NUM_COLS-1:0] col_drive;
  code_t               key_code;
  logic                key_press;

  modport master (input row_in, output col_drive, key_code, key_press);
  modport slave  (output row_in, input col_drive, key_code, key_press);
endinterface

// File: rtl/keypad_debounce.sv
// Frame-level debounce: a candidate must repeat for DEBOUNCE_SCANS frames before it is published.
module keypad_debounce import keypad_pkg::*; #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic  mclk,
  input  logic  rst_n,
  input  logic  frame_done,
  input  code_t frame_cand,
  output code_t key_code,
  output logic  key_press
);
  localparam int              SW         = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0]   STABLE_MAX = SW'(DEBOUNCE_SCANS);

  code_t         prev_cand;
  logic [SW-1:0] stable_cnt, stable_nx;

  always_comb begin
    stable_nx = SW'(1);
    if (frame_cand == prev_cand)
      stable_nx = (stable_cnt == STABLE_MAX) ? STABLE_MAX : stable_cnt + SW'(1);
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cand  <= KEY_NONE;
      stable_cnt <= '0;
      key_code   <= KEY_NONE;
      key_press  <= 1'b0;
    end else begin
      key_press <= 1'b0;
      if (frame_done) begin
        prev_cand  <= frame_cand;
        stable_cnt <= stable_nx;
        // Saturation keeps a held key from re-publishing; the code compare blocks repeats.
        if (stable_nx == STABLE_MAX && frame_cand != key_code) begin
          key_code  <= frame_cand;
          key_press <= (frame_cand != KEY_NONE);
        end
      end
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: row sync, dwell/column sequencing, per-frame candidate capture.
module keypad_scanner import keypad_pkg::*; #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic               mclk,
  input  logic               rst_n,
  keypad_scanner_if.master   kp
);
  localparam int            DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [NUM_ROWS-1:0] row_s1, row_s2;
  logic [DW-1:0]       dwell_cnt;
  logic [1:0]          col_idx;
  code_t               cand, cand_nx, hit_code;
  logic                hit, sample, frame_done;
  code_t               key_code;
  logic                key_press;

  // Sampling at the last dwell cycle gives the column drive time to settle through the sync.
  assign sample     = (dwell_cnt == DWELL_LAST);
  assign frame_done = sample && (col_idx == 2'd3);

  always_comb begin
    hit      = 1'b0;
    hit_code = KEY_NONE;
    for (int r = NUM_ROWS - 1; r >= 0; r--)
      if (!row_s2[r]) begin
        hit      = 1'b1;
        hit_code = code_of(col_idx, 2'(r));
      end
    cand_nx = (cand == KEY_NONE && hit) ? hit_code : cand;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1    <= '1;
      row_s2    <= '1;
      dwell_cnt <= '0;
      col_idx   <= '0;
      cand      <= KEY_NONE;
    end else begin
      row_s1 <= kp.row_in;
      row_s2 <= row_s1;
      if (sample) begin
        dwell_cnt <= '0;
        col_idx   <= col_idx + 2'd1;
        cand      <= frame_done ? KEY_NONE : cand_nx;
      end else begin
        dwell_cnt <= dwell_cnt + DW'(1);
      end
    end
  end

  assign kp.col_drive = ~(NUM_COLS'(1) << col_idx);

  keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb (
    .mclk       (mclk),
    .rst_n      (rst_n),
    .frame_done (frame_done),
    .frame_cand (cand_nx),
    .key_code   (key_code),
    .key_press  (key_press)
  );

  assign kp.key_code  = key_code;
  assign kp.key_press = key_press;
endmodule

// File: tb/tb_keypad_scanner.sv
// Frame-aligned random/directed bench with an ideal keypad matrix and a frame-history reference model.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SD    = 4;
  localparam int DB    = 2;
  localparam int FRAME = 4 * SD;

  logic mclk  = 1'b0;
  logic rst_n = 1'b1;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .kp    (kp.master)
  );

  always #5 mclk = ~mclk;

  // Ideal matrix: a pressed key pulls its row low while its column is driven.
  logic [16:1] pressed    = '0;
  logic [3:0]  glitch_low = '0;
  logic [3:0]  row_v;

  always_comb begin
    row_v = ~glitch_low;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!kp.col_drive[c] && pressed[c*4 + r + 1]) row_v[r] = 1'b0;
  end
  assign kp.row_in = row_v;

  int    n_chk  = 0;
  int    n_fail = 0;
  code_t hist[$];
  code_t m_code  = KEY_NONE;
  logic  m_press = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic code_t lowest(input logic [16:1] p);
    for (int k = 1; k <= 16; k++)
      if (p[k]) return code_t'(k);
    return KEY_NONE;
  endfunction

  // Publish a code once the last DB frames all agree on it and it differs from the current one.
  task automatic model_frame(input code_t c);
    bit same;
    hist.push_back(c);
    m_press = 1'b0;
    if (hist.size() >= DB) begin
      same = 1'b1;
      for (int i = 0; i < DB; i++)
        if (hist[hist.size() - 1 - i] != c) same = 1'b0;
      if (same && c != m_code) begin
        m_code  = c;
        m_press = (c != KEY_NONE);
      end
    end
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  // Called at posedge+1 on a frame boundary; returns at the next frame boundary.
  task automatic run_frame(input logic [16:1] keys, input int glitch_col);
    logic [3:0] exp_col;
    pressed = keys;
    for (int i = 0; i < FRAME; i++) begin
      // Glitch window skips the dwell's second cycle, the only one whose row value reaches the sampler.
      glitch_low = (glitch_col >= 0 && i >= glitch_col*SD + 2 && i <= glitch_col*SD + 4) ? 4'b0100 : 4'b0000;
      @(negedge mclk);
      exp_col = 4'b1111;
      exp_col[i / SD] = 1'b0;
      chk("col_drive", kp.col_drive, exp_col);
      chk("key_code", kp.key_code, m_code);
      chk("key_press", kp.key_press, (i == 0) ? m_press : 1'b0);
      @(posedge mclk);
      #1;
    end
    glitch_low = '0;
    model_frame(lowest(keys));
  endtask

  task automatic hold(input logic [16:1] keys, input int frames);
    for (int f = 0; f < frames; f++) run_frame(keys, -1);
  endtask

  // Asserts reset mid-cycle after n clocks, checks outputs asynchronously, releases on a frame boundary.
  task automatic do_reset(input int n);
    repeat (n) @(posedge mclk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_col", kp.col_drive, 4'b1110);
    chk("rst_code", kp.key_code, KEY_NONE);
    chk("rst_press", kp.key_press, 1'b0);
    hist.delete();
    m_code  = KEY_NONE;
    m_press = 1'b0;
    @(posedge mclk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [16:1] k1(input int a);
    logic [16:1] v;
    v = '0;
    if (a >= 1 && a <= 16) v[a] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [16:1] keys;
    int          nk, kk, rep;

    do_reset(1);

    // Clean press of column 2 / row 1, then a long hold.
    hold(k1(10), 12);
    chk("held_code", kp.key_code, 10);

    // Release, then re-press.
    hold('0, 3);
    hold(k1(10), 3);

    // Reset in the middle of a dwell while a key is published.
    chk("pre_rst_code", kp.key_code, 10);
    do_reset(6);

    // Bounce: alternating frames never qualify, then a steady hold does.
    for (int f = 0; f < 6; f++) run_frame((f % 2 == 0) ? k1(1) : '0, -1);
    hold(k1(1), 3);
    chk("bounce_code", kp.key_code, 1);
    hold('0, 3);

    // Two keys: lowest wins, then a direct hand-over to the remaining key.
    hold(k1(7) | k1(14), 3);
    chk("two_key_code", kp.key_code, 7);
    hold(k1(14), 3);
    chk("handover_code", kp.key_code, 14);
    hold('0, 3);

    // Short row glitch on column 1.
    run_frame('0, 1);
    hold('0, 2);
    chk("glitch_code", kp.key_code, 0);

    // Randomized key sets held for random frame counts.
    for (int it = 0; it < 40; it++) begin
      keys = '0;
      nk = $urandom_range(0, 2);
      for (int j = 0; j < nk; j++) begin
        kk = $urandom_range(1, 16);
        keys[kk] = 1'b1;
      end
      rep = $urandom_range(1, 4);
      hold(keys, rep);
    end
    hold('0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
